mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 20 ++
 rtl/mem_loader_byte_packer.sv | 35 +++
 rtl/mem_loader.sv | 173 +++++++++++++++++
 tb/tb_mem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared parameters for the motion-estimation loader and control logic.
// State encoding and reference-window sizing live here.
package mem_loader_pkg;

  localparam int DEF_CUR_WORDS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CUR,
    S_LOAD_REF,
    S_GO,
    S_WAIT_ME
  } ml_state_e;

  // Reference window is 64 words per search-range step.
  function automatic logic [8:0] ref_words(input logic [1:0] r);
    return {1'b0, r, 6'd0} + 9'd64;
  endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// 8-to-64 little-endian byte packer with a word-complete strobe.
// The completed word is presented combinationally with the 8th byte.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] word_o,
  output logic        full_o
);

  logic [2:0]  cnt_q;
  logic [63:0] data_q;
  logic [63:0] word_d;

  always_comb begin
    word_d = data_q;
    word_d[{cnt_q, 3'b000} +: 8] = byte_i;
  end

  assign word_o = word_d;
  assign full_o = push_i && (cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q  <= 3'd0;
      data_q <= 64'd0;
    end else if (push_i) begin
      cnt_q  <= cnt_q + 3'd1;
      data_q <= word_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Loads the current block then the reference window into on-chip memory,
// then kicks the motion-estimation controller and waits for it to start.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int CUR_WORDS = DEF_CUR_WORDS,
  parameter int CUR_AW    = 5,
  parameter int REF_AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic [1:0]        r,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              wenCur,
  output logic [CUR_AW-1:0] waddrCur,
  output logic [63:0]       wdatCur,
  output logic              wenRef,
  output logic [REF_AW-1:0] waddrRef,
  output logic [63:0]       wdatRef,
  output logic              go,
  input  logic              me_start,
  output logic              busy,
  output logic              err
);

  localparam logic [8:0] CUR_LAST = 9'(CUR_WORDS - 1);

  ml_state_e         state_q, state_d;
  logic [1:0]        r_q, r_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              go_q, go_d;
  logic              wenCur_q, wenCur_d;
  logic              wenRef_q, wenRef_d;
  logic [CUR_AW-1:0] waddrCur_q, waddrCur_d;
  logic [REF_AW-1:0] waddrRef_q, waddrRef_d;
  logic [63:0]       wdatCur_q, wdatCur_d;
  logic [63:0]       wdatRef_q, wdatRef_d;

  logic        accept;
  logic        clr;
  logic        full;
  logic        is_final;
  logic [63:0] word;

  assign in_ready = (state_q == S_LOAD_CUR) || (state_q == S_LOAD_REF);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign is_final = full && (wcnt_q == ref_words(r_q) - 9'd1);

  byte_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .push_i (accept),
    .byte_i (in_data),
    .word_o (word),
    .full_o (full)
  );

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    go_d       = 1'b0;
    wenCur_d   = 1'b0;
    wenRef_d   = 1'b0;
    waddrCur_d = waddrCur_q;
    waddrRef_d = waddrRef_q;
    wdatCur_d  = wdatCur_q;
    wdatRef_d  = wdatRef_q;
    clr        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clr = 1'b1;
        if (start_load) begin
          state_d = S_LOAD_CUR;
          r_d     = r;
          err_d   = 1'b0;
          wcnt_d  = 9'd0;
        end
      end
      S_LOAD_CUR: begin
        if (accept) begin
          if (in_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (full) begin
            wenCur_d   = 1'b1;
            waddrCur_d = wcnt_q[CUR_AW-1:0];
            wdatCur_d  = word;
            if (wcnt_q == CUR_LAST) begin
              wcnt_d  = 9'd0;
              state_d = S_LOAD_REF;
            end else begin
              wcnt_d = wcnt_q + 9'd1;
            end
          end
        end
      end
      S_LOAD_REF: begin
        if (accept) begin
          if (in_last && !is_final) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (full) begin
            wenRef_d   = 1'b1;
            waddrRef_d = wcnt_q[REF_AW-1:0];
            wdatRef_d  = word;
            if (is_final) begin
              // Missing in_last still commits the final word.
              err_d   = !in_last;
              state_d = in_last ? S_GO : S_IDLE;
            end else begin
              wcnt_d = wcnt_q + 9'd1;
            end
          end
        end
      end
      S_GO: begin
        go_d    = 1'b1;
        state_d = S_WAIT_ME;
      end
      S_WAIT_ME: begin
        if (me_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      r_q        <= 2'd0;
      wcnt_q     <= 9'd0;
      err_q      <= 1'b0;
      go_q       <= 1'b0;
      wenCur_q   <= 1'b0;
      wenRef_q   <= 1'b0;
      waddrCur_q <= '0;
      waddrRef_q <= '0;
      wdatCur_q  <= 64'd0;
      wdatRef_q  <= 64'd0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      go_q       <= go_d;
      wenCur_q   <= wenCur_d;
      wenRef_q   <= wenRef_d;
      waddrCur_q <= waddrCur_d;
      waddrRef_q <= waddrRef_d;
      wdatCur_q  <= wdatCur_d;
      wdatRef_q  <= wdatRef_d;
    end
  end

  assign wenCur   = wenCur_q;
  assign waddrCur = waddrCur_q;
  assign wdatCur  = wdatCur_q;
  assign wenRef   = wenRef_q;
  assign waddrRef = waddrRef_q;
  assign wdatRef  = wdatRef_q;
  assign go       = go_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader against a byte-level stream model.
// Expected writes are queued from the byte list; a negedge monitor pops them.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_load;
  logic [1:0]  r;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        wenCur;
  logic [4:0]  waddrCur;
  logic [63:0] wdatCur;
  logic        wenRef;
  logic [7:0]  waddrRef;
  logic [63:0] wdatRef;
  logic        go;
  logic        me_start;
  logic        busy;
  logic        err;

  mem_loader #(.CUR_WORDS(32), .CUR_AW(5), .REF_AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_load (start_load),
    .r          (r),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .wenCur     (wenCur),
    .waddrCur   (waddrCur),
    .wdatCur    (wdatCur),
    .wenRef     (wenRef),
    .waddrRef   (waddrRef),
    .wdatRef    (wdatRef),
    .go         (go),
    .me_start   (me_start),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  addr;
    logic [63:0] data;
  } wr_t;

  int total_n = 0;
  int bad_n   = 0;

  wr_t        q_cur[$];
  wr_t        q_ref[$];
  logic [7:0] bytes[$];
  bit         lasts[$];
  wr_t        wc;
  wr_t        wr;
  int         exp_go;
  bit         exp_err;
  int         nfeed;
  int         go_cnt;
  int         n_cur;
  int         n_ref;
  logic [63:0] first_cur;
  int         last_ref_addr;
  bit         chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (wenCur) begin
        if (q_cur.size() == 0) check("spurious wenCur", wenCur, 0);
        else begin
          wc = q_cur.pop_front();
          check("waddrCur", 64'(waddrCur), 64'(wc.addr));
          check("wdatCur", wdatCur, wc.data);
        end
        if (n_cur == 0) first_cur = wdatCur;
        n_cur++;
      end
      if (wenRef) begin
        if (q_ref.size() == 0) check("spurious wenRef", wenRef, 0);
        else begin
          wr = q_ref.pop_front();
          check("waddrRef", 64'(waddrRef), 64'(wr.addr));
          check("wdatRef", wdatRef, wr.data);
        end
        last_ref_addr = int'(waddrRef);
        n_ref++;
      end
      if (go) go_cnt++;
    end
  end

  // Stream model: what the loader must write for a given byte list.
  task automatic build(input int rr, input int err_idx, input bit drop_last,
                       input bit rnd_data, input int stop_at);
    int total;
    logic [63:0] acc;
    bytes.delete(); lasts.delete();
    q_cur.delete(); q_ref.delete();
    total = 256 + 512 * (rr + 1);
    for (int i = 0; i < total; i++) begin
      bytes.push_back(rnd_data ? 8'($urandom) : 8'(i));
      lasts.push_back((i == total - 1 && !drop_last) || i == err_idx);
    end
    exp_go = 0; exp_err = 1'b0; nfeed = 0;
    go_cnt = 0; n_cur = 0; n_ref = 0;
    first_cur = '0; last_ref_addr = -1;
    acc = '0;
    for (int i = 0; i < total && i < stop_at; i++) begin
      nfeed = i + 1;
      acc[(i % 8) * 8 +: 8] = bytes[i];
      if (lasts[i] && i != total - 1) begin
        exp_err = 1'b1;
        break;
      end
      if (i % 8 == 7) begin
        if (i < 256) q_cur.push_back({9'(i / 8), acc});
        else q_ref.push_back({9'((i - 256) / 8), acc});
      end
      if (i == total - 1) begin
        if (lasts[i]) exp_go = 1;
        else exp_err = 1'b1;
      end
    end
  endtask

  task automatic kick(input int rr);
    @(negedge clk);
    r = rr[1:0];
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    check("busy after start", busy, 1);
    check("err cleared by start", err, 0);
  endtask

  task automatic feed(input bit rnd);
    int i = 0;
    int guard = 0;
    while (i < nfeed && guard < 20000) begin
      @(negedge clk);
      guard++;
      in_data  = bytes[i];
      in_last  = lasts[i];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("feed completed", 64'(i), 64'(nfeed));
  endtask

  task automatic wrap_up();
    int k = 0;
    if (exp_go != 0) begin
      while (!go && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("go pulse", go, 1);
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        check("busy in WAIT_ME", busy, 1);
        start_load = (c == 10);
      end
      @(negedge clk);
      start_load = 1'b0;
      me_start = 1'b1;
      check("busy at me_start", busy, 1);
      @(negedge clk);
      me_start = 1'b0;
      check("busy after me_start", busy, 0);
    end else begin
      repeat (3) @(negedge clk);
    end
    check("busy idle", busy, 0);
    check("in_ready idle", in_ready, 0);
    check("err final", err, exp_err);
    check("go count", 64'(go_cnt), 64'(exp_go));
    check("cur writes left", 64'(q_cur.size()), 0);
    check("ref writes left", 64'(q_ref.size()), 0);
  endtask

  initial begin
    reset = 1'b1; start_load = 1'b0; r = 2'd0;
    in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; me_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    check("rst wenCur", wenCur, 0);
    check("rst wenRef", wenRef, 0);
    check("rst go", go, 0);
    check("rst err", err, 0);
    check("rst waddrRef", 64'(waddrRef), 0);
    check("rst wdatCur", wdatCur, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // r=0 counting pattern, continuous valid
    build(0, -1, 1'b0, 1'b0, 1 << 30);
    kick(0); feed(1'b0); wrap_up();
    check("r0 cur count", 64'(n_cur), 32);
    check("r0 ref count", 64'(n_ref), 64);
    check("r0 last waddrRef", 64'(last_ref_addr), 63);
    check("r0 word0", first_cur, 64'h0706050403020100);

    // r=3 random data and random valid
    build(3, -1, 1'b0, 1'b1, 1 << 30);
    kick(3); feed(1'b1); wrap_up();
    check("r3 ref count", 64'(n_ref), 256);
    check("r3 last waddrRef", 64'(last_ref_addr), 255);

    // early in_last on byte 100 of the current block
    build(1, 100, 1'b0, 1'b1, 1 << 30);
    kick(1); feed(1'b1); wrap_up();
    check("early last cur count", 64'(n_cur), 12);

    // r=1, final in_last missing
    build(1, -1, 1'b1, 1'b1, 1 << 30);
    kick(1); feed(1'b1); wrap_up();
    check("no-last ref count", 64'(n_ref), 128);

    // stray in_last inside the reference phase
    build(0, 256 + 77, 1'b0, 1'b1, 1 << 30);
    kick(0); feed(1'b1); wrap_up();
    check("stray last ref count", 64'(n_ref), 9);

    // reset in the middle of reference word 10
    build(2, -1, 1'b0, 1'b1, 256 + 83);
    kick(2); feed(1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort in_ready", in_ready, 0);
    check("abort wenRef", wenRef, 0);
    check("abort go", go, 0);
    check("abort err", err, 0);
    check("abort waddrRef", 64'(waddrRef), 0);
    check("abort wdatRef", wdatRef, 0);
    check("abort ref left", 64'(q_ref.size()), 0);
    reset = 1'b0;

    build(0, -1, 1'b0, 1'b1, 1 << 30);
    kick(0); feed(1'b1); wrap_up();
    check("post-abort ref count", 64'(n_ref), 64);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
